// File: rtl/npu_host_master_if.sv
// Command, response and slave-bus signal bundle for npu_host_master.
// Handshakes: a transfer happens on a rising clk edge where valid && ready; valid, once raised, holds its payload stable until that edge.
interface npu_host_master_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 12
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_data;
   logic [DATA_W-1:0] cmd_mask;
   logic [LEN_W-1:0]  cmd_len;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;
   logic              busy;
   logic              ena;
   logic              wea;
   logic [ADDR_W-1:0] addra;
   logic [DATA_W-1:0] dina;
   logic [DATA_W-1:0] douta;

   modport master (
      input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, cmd_len, rsp_ready, douta,
      output cmd_ready, rsp_valid, rsp_data, rsp_err, busy, ena, wea, addra, dina
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, cmd_len, rsp_ready, douta,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy, ena, wea, addra, dina
   );
endinterface

// File: rtl/npu_host_master.sv
// Host-side initiator: turns WRITE/READ/POLL/FILL commands into single-port slave
// transactions and returns one response per command.
module npu_host_master #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 32,
   parameter int LEN_W    = 12,
   parameter int POLL_MAX = 1024,
   parameter int POLL_GAP = 2
) (
   input  logic                clk,
   input  logic                rst_ni,
   npu_host_master_if.master   bus,
   output logic [2:0]          state_dbg
);

   typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_CAP, GAP, RSP} state_t;

   localparam int PW = $clog2(POLL_MAX + 1);
   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_POLL  = 2'b10;
   localparam logic [1:0] OP_FILL  = 2'b11;

   state_t            state, state_n;
   logic [1:0]        op_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] mask_q;
   logic [LEN_W-1:0]  fill_cnt;
   logic [PW-1:0]     poll_cnt;
   logic [GW-1:0]     gap_cnt;
   logic              accept;
   logic              poll_hit;
   logic              poll_done;
   logic              cmd_is_wr;

   // Ready is forced low while reset is held, not just after the first edge.
   assign bus.cmd_ready = rst_ni && (state == IDLE);
   assign bus.rsp_valid = (state == RSP);
   assign bus.busy      = (state != IDLE);
   assign state_dbg     = state;

   assign accept    = bus.cmd_valid && bus.cmd_ready;
   assign cmd_is_wr = (bus.cmd_op == OP_WRITE) || (bus.cmd_op == OP_FILL);
   assign poll_hit  = ((bus.douta ^ data_q) & mask_q) == '0;
   assign poll_done = (poll_cnt == PW'(POLL_MAX));

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:   if (accept) state_n = cmd_is_wr ? WR : RD_REQ;
         WR:     if (fill_cnt == '0) state_n = RSP;
         RD_REQ: state_n = RD_CAP;
         RD_CAP: begin
            if (op_q != OP_POLL || poll_hit || poll_done) state_n = RSP;
            else if (POLL_GAP == 0)                       state_n = RD_REQ;
            else                                          state_n = GAP;
         end
         GAP:    if (gap_cnt == '0) state_n = RD_REQ;
         RSP:    if (bus.rsp_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Bus strobes are registered from the next state so they line up with WR/RD_REQ.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         bus.ena      <= 1'b0;
         bus.wea      <= 1'b0;
         bus.addra    <= '0;
         bus.dina     <= '0;
         bus.rsp_data <= '0;
         bus.rsp_err  <= 1'b0;
         op_q         <= OP_WRITE;
         data_q       <= '0;
         mask_q       <= '0;
         fill_cnt     <= '0;
         poll_cnt     <= '0;
         gap_cnt      <= '0;
      end else begin
         bus.ena <= (state_n == WR) || (state_n == RD_REQ);
         bus.wea <= (state_n == WR);

         if (accept) begin
            op_q         <= bus.cmd_op;
            data_q       <= bus.cmd_data;
            mask_q       <= bus.cmd_mask;
            bus.addra    <= bus.cmd_addr;
            fill_cnt     <= (bus.cmd_len == '0) ? '0 : bus.cmd_len - 1'b1;
            poll_cnt     <= '0;
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b0;
            if (cmd_is_wr) bus.dina <= bus.cmd_data;
         end

         if (state == WR && state_n == WR) begin
            bus.addra <= bus.addra + 1'b1;
            fill_cnt  <= fill_cnt - 1'b1;
         end

         if (state == RD_REQ && op_q == OP_POLL) poll_cnt <= poll_cnt + 1'b1;

         if (state == RD_CAP) begin
            bus.rsp_data <= bus.douta;
            bus.rsp_err  <= (op_q == OP_POLL) && !poll_hit && poll_done;
            gap_cnt      <= GW'(POLL_GAP - 1);
         end

         if (state == GAP) gap_cnt <= gap_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_npu_host_master.sv
// Directed bench for npu_host_master: slave model, write/read monitor, immediate-assert checks.
module tb_npu_host_master;

   logic       clk;
   logic       rst_ni;
   logic [2:0] state_dbg;

   npu_host_master_if #(.ADDR_W(16), .DATA_W(32), .LEN_W(12)) bus ();

   npu_host_master #(
      .ADDR_W(16), .DATA_W(32), .LEN_W(12), .POLL_MAX(4), .POLL_GAP(2)
   ) dut (
      .clk       (clk),
      .rst_ni    (rst_ni),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- slave model and monitor ----------------
   int          cyc = 0;
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          rsp_cnt = 0;
   logic [15:0] wr_addr [256];
   logic [31:0] wr_data [256];
   int          wr_cyc  [256];
   logic [15:0] rd_addr [64];
   int          rd_cyc  [64];
   logic [31:0] seq [8];
   int          seq_base = 0;

   initial bus.douta = '0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (bus.ena && bus.wea) begin
         wr_addr[wr_cnt & 255] = bus.addra;
         wr_data[wr_cnt & 255] = bus.dina;
         wr_cyc[wr_cnt & 255]  = cyc;
         wr_cnt = wr_cnt + 1;
      end
      if (bus.ena && !bus.wea) begin
         rd_addr[rd_cnt & 63] = bus.addra;
         rd_cyc[rd_cnt & 63]  = cyc;
         bus.douta <= seq[(rd_cnt - seq_base) & 7];
         rd_cnt = rd_cnt + 1;
      end
      if (bus.rsp_valid && bus.rsp_ready) rsp_cnt = rsp_cnt + 1;
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic send(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] data,
                       input logic [31:0] mask, input logic [11:0] len);
      int n;
      n = 0;
      bus.cmd_op    = op;
      bus.cmd_addr  = addr;
      bus.cmd_data  = data;
      bus.cmd_mask  = mask;
      bus.cmd_len   = len;
      bus.cmd_valid = 1'b1;
      while (!bus.cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_accept", 32'(bus.cmd_ready), 32'd1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = 16'(($urandom_range(0, 65535)));
      bus.cmd_data  = $urandom_range(0, 32'h7fffffff);
      bus.cmd_mask  = $urandom_range(0, 32'h7fffffff);
      bus.cmd_len   = 12'(($urandom_range(0, 4095)));
   endtask

   // Latency in cycles from the acceptance cycle to the first cycle with rsp_valid.
   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!bus.rsp_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("rsp_seen", 32'(bus.rsp_valid), 32'd1);
   endtask

   task automatic take_rsp();
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   int lat;
   int wb, rb, sb, bad;

   initial begin
      rst_ni        = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_addr  = '0;
      bus.cmd_data  = '0;
      bus.cmd_mask  = '0;
      bus.cmd_len   = '0;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 8; i++) seq[i] = '0;

      // reset state
      @(negedge clk);
      chk("rst_ena", 32'(bus.ena), 32'd0);
      chk("rst_wea", 32'(bus.wea), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("rst_addra", 32'(bus.addra), 32'd0);
      chk("rst_rsp_data", bus.rsp_data, 32'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

      // WRITE
      wb = wr_cnt;
      send(2'b00, 16'h2000, 32'h04030201, 32'h0, 12'd0);
      wait_rsp(lat);
      chk("wr_latency", 32'(lat), 32'd2);
      chk("wr_count", 32'(wr_cnt - wb), 32'd1);
      chk("wr_addr", 32'(wr_addr[wb & 255]), 32'h2000);
      chk("wr_data", wr_data[wb & 255], 32'h04030201);
      chk("wr_rsp_data", bus.rsp_data, 32'd0);
      chk("wr_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("wr_cmd_ready_in_rsp", 32'(bus.cmd_ready), 32'd0);
      take_rsp();
      chk("wr_idle_ready", 32'(bus.cmd_ready), 32'd1);
      chk("wr_idle_busy", 32'(bus.busy), 32'd0);

      // FILL 60 words
      wb = wr_cnt;
      sb = rsp_cnt;
      send(2'b11, 16'h1000, 32'h0, 32'h0, 12'd60);
      wait_rsp(lat);
      chk("fill_latency", 32'(lat), 32'd61);
      chk("fill_count", 32'(wr_cnt - wb), 32'd60);
      chk("fill_first_addr", 32'(wr_addr[wb & 255]), 32'h1000);
      chk("fill_last_addr", 32'(wr_addr[(wb + 59) & 255]), 32'h103B);
      chk("fill_back_to_back", 32'(wr_cyc[(wb + 59) & 255] - wr_cyc[wb & 255]), 32'd59);
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         if (wr_addr[(wb + i) & 255] != 16'(16'h1000 + i)) bad++;
         if (wr_data[(wb + i) & 255] != 32'h0) bad++;
      end
      chk("fill_addr_data_seq", 32'(bad), 32'd0);
      take_rsp();
      chk("fill_single_rsp", 32'(rsp_cnt - sb), 32'd1);

      // FILL len=0 -> one write
      wb = wr_cnt;
      send(2'b11, 16'h1500, 32'hA5A5A5A5, 32'h0, 12'd0);
      wait_rsp(lat);
      chk("fill0_latency", 32'(lat), 32'd2);
      chk("fill0_count", 32'(wr_cnt - wb), 32'd1);
      chk("fill0_data", wr_data[wb & 255], 32'hA5A5A5A5);
      take_rsp();

      // READ with back-pressure
      rb = rd_cnt;
      seq_base = rd_cnt;
      seq[0] = 32'hFFFFFF85;
      send(2'b01, 16'h7004, 32'h0, 32'h0, 12'd0);
      wait_rsp(lat);
      chk("rd_latency", 32'(lat), 32'd3);
      chk("rd_count", 32'(rd_cnt - rb), 32'd1);
      chk("rd_addr", 32'(rd_addr[rb & 63]), 32'h7004);
      chk("rd_data", bus.rsp_data, 32'hFFFFFF85);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rd_hold_valid", 32'(bus.rsp_valid), 32'd1);
         chk("rd_hold_data", bus.rsp_data, 32'hFFFFFF85);
         chk("rd_hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      end
      take_rsp();

      // POLL matching on the 4th read
      rb = rd_cnt;
      seq_base = rd_cnt;
      seq[0] = 32'h0; seq[1] = 32'hFFFFFFFE; seq[2] = 32'h10; seq[3] = 32'h1;
      send(2'b10, 16'h7000, 32'h1, 32'h1, 12'd0);
      wait_rsp(lat);
      chk("poll_latency", 32'(lat), 32'd15);
      chk("poll_reads", 32'(rd_cnt - rb), 32'd4);
      for (int i = 0; i < 3; i++)
         chk("poll_spacing", 32'(rd_cyc[(rb + i + 1) & 63] - rd_cyc[(rb + i) & 63]), 32'd4);
      chk("poll_addr", 32'(rd_addr[(rb + 3) & 63]), 32'h7000);
      chk("poll_err", 32'(bus.rsp_err), 32'd0);
      chk("poll_data", bus.rsp_data, 32'h1);
      take_rsp();

      // POLL timeout after POLL_MAX=4 reads
      rb = rd_cnt;
      seq_base = rd_cnt;
      seq[0] = 32'h2; seq[1] = 32'h4; seq[2] = 32'h6; seq[3] = 32'h8;
      send(2'b10, 16'h7000, 32'h1, 32'h1, 12'd0);
      wait_rsp(lat);
      chk("poll_to_latency", 32'(lat), 32'd15);
      chk("poll_to_reads", 32'(rd_cnt - rb), 32'd4);
      chk("poll_to_err", 32'(bus.rsp_err), 32'd1);
      chk("poll_to_data", bus.rsp_data, 32'h8);
      take_rsp();
      repeat (4) @(negedge clk);
      chk("poll_to_no_extra_read", 32'(rd_cnt - rb), 32'd4);

      // POLL with mask=0 matches at once
      rb = rd_cnt;
      seq_base = rd_cnt;
      seq[0] = 32'h55;
      send(2'b10, 16'h7008, 32'hFFFF0000, 32'h0, 12'd0);
      wait_rsp(lat);
      chk("poll_m0_latency", 32'(lat), 32'd3);
      chk("poll_m0_reads", 32'(rd_cnt - rb), 32'd1);
      chk("poll_m0_err", 32'(bus.rsp_err), 32'd0);
      chk("poll_m0_data", bus.rsp_data, 32'h55);
      take_rsp();

      // Reset in the middle of a FILL
      wb = wr_cnt;
      sb = rsp_cnt;
      send(2'b11, 16'h1000, 32'h12345678, 32'h0, 12'd8);
      repeat (3) @(negedge clk);
      chk("midrst_writes_before", 32'(wr_cnt - wb), 32'd3);
      rst_ni = 1'b0;
      #1;
      chk("midrst_ena", 32'(bus.ena), 32'd0);
      chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      chk("midrst_ready_after", 32'(bus.cmd_ready), 32'd1);
      repeat (10) @(negedge clk);
      chk("midrst_no_rsp", 32'(rsp_cnt - sb), 32'd0);
      chk("midrst_rsp_valid_after", 32'(bus.rsp_valid), 32'd0);
      chk("midrst_writes_total", 32'(wr_cnt - wb), 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
